// File: rtl/uart_rx_edge_bit_sampler.sv
// UART RX timing/sampling stage: per-bit edge counter, per-frame bit counter, mid-bit sampler.
// Define UART_RX_MAJORITY_SAMP_EN for a 3-point majority vote; the default build takes a single mid-bit sample.
module uart_rx_edge_bit_sampler #(
    parameter int PRESCALE = 8,
    parameter int EDGE_W   = 3,
    parameter int BIT_W    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              S_DATA,
    input  logic              edge_bit_en,
    input  logic              dat_samp_en,
    output logic [EDGE_W-1:0] edge_count,
    output logic [BIT_W-1:0]  bit_count,
    output logic              sampled_bit,
    output logic              samp_valid
);

    localparam logic [EDGE_W-1:0] LP_LAST   = EDGE_W'(PRESCALE - 1);
    localparam logic [EDGE_W-1:0] LP_MID    = EDGE_W'(PRESCALE / 2);
    localparam logic [EDGE_W-1:0] LP_MID_M1 = EDGE_W'(PRESCALE / 2 - 1);
    localparam logic [EDGE_W-1:0] LP_MID_P1 = EDGE_W'(PRESCALE / 2 + 1);

    logic [EDGE_W-1:0] r_edge_count;
    logic [BIT_W-1:0]  r_bit_count;
    logic              r_sampled_bit;
    logic              r_samp_valid;
    logic              w_fire;
    logic              w_decision;

    // Dropping edge_bit_en aborts the frame; bit_count saturates so a stuck FSM cannot wrap it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_count <= '0;
            r_bit_count  <= '0;
        end else if (!edge_bit_en) begin
            r_edge_count <= '0;
            r_bit_count  <= '0;
        end else if (r_edge_count == LP_LAST) begin
            r_edge_count <= '0;
            if (r_bit_count != '1)
                r_bit_count <= r_bit_count + BIT_W'(1);
        end else begin
            r_edge_count <= r_edge_count + EDGE_W'(1);
        end
    end

`ifdef UART_RX_MAJORITY_SAMP_EN
    logic r_s0;
    logic r_s1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else if (dat_samp_en) begin
            if (r_edge_count == LP_MID_M1)
                r_s0 <= S_DATA;
            if (r_edge_count == LP_MID)
                r_s1 <= S_DATA;
        end
    end

    always_comb begin
        w_fire     = dat_samp_en && (r_edge_count == LP_MID_P1);
        w_decision = (r_s0 & r_s1) | (r_s0 & S_DATA) | (r_s1 & S_DATA);
    end
`else
    always_comb begin
        w_fire     = dat_samp_en && (r_edge_count == LP_MID);
        w_decision = S_DATA;
    end

    logic [1:0] w_unused;
    assign w_unused = {LP_MID_M1[0], LP_MID_P1[0]};
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sampled_bit <= 1'b1;
            r_samp_valid  <= 1'b0;
        end else begin
            r_samp_valid <= w_fire;
            if (w_fire)
                r_sampled_bit <= w_decision;
        end
    end

    assign edge_count  = r_edge_count;
    assign bit_count   = r_bit_count;
    assign sampled_bit = r_sampled_bit;
    assign samp_valid  = r_samp_valid;

endmodule
